// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default field widths, flag bit positions,
// rounding modes and the canonical quiet NaN pattern.
package fpu_pkg;

  localparam int FPU_EXP_W  = 8;
  localparam int FPU_FRAC_W = 23;
  localparam int FPU_MAX_W  = 128;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Only RNE is implemented; the other encodings are held for later units.
  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } round_mode_e;

  function automatic logic [FPU_MAX_W-1:0] fpu_qnan(input int exp_w, input int frac_w);
    logic [FPU_MAX_W-1:0] q;
    q = '0;
    for (int i = 0; i < FPU_MAX_W; i++) begin
      if (i >= frac_w - 1 && i < frac_w + exp_w) q[i] = 1'b1;
    end
    return q;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; reports WIDTH and o_zero when the input is all zero.
module fpu_lzc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]             i_data,
  output logic [$clog2(WIDTH+1)-1:0]   o_count,
  output logic                         o_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    o_count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CW'(WIDTH - 1 - i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/faddsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor (align, add+LZC, normalise/round/pack)
// with round-to-nearest-even, denormal flush and a stall-all valid/ready pipe.
module faddsub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = FPU_EXP_W,
  parameter int FRAC_W = FPU_FRAC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+FRAC_W:0]    op1,
  input  logic [EXP_W+FRAC_W:0]    op2,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+FRAC_W:0]    result,
  output logic [3:0]               flags
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 4;
  localparam int S  = FRAC_W + 5;
  localparam int CW = $clog2(S + 1);
  localparam int EP = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EP-1:0]    E_OVF    = EP'(2**EXP_W - 1);
  localparam logic [W-1:0]     QNAN     = W'(fpu_qnan(EXP_W, FRAC_W));

  logic w_en;
  logic r_v1, r_v2, r_v3;
  logic [W-1:0] r_result;
  logic [3:0]   r_flags;

  assign w_en      = !r_v3 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign result    = r_result;
  assign flags     = r_flags;

  // ---------------- stage 1: unpack, specials, swap, align
  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W-1:0] w_fa_raw, w_fb_raw, w_fa, w_fb;
  logic              w_za, w_zb, w_nan_a, w_nan_b, w_snan_a, w_snan_b, w_inf_a, w_inf_b;
  logic [M-1:0]      w_sig_a, w_sig_b;

  assign w_sa     = op1[W-1];
  assign w_sb     = op2[W-1] ^ sub;
  assign w_ea     = op1[W-2:FRAC_W];
  assign w_eb     = op2[W-2:FRAC_W];
  assign w_fa_raw = op1[FRAC_W-1:0];
  assign w_fb_raw = op2[FRAC_W-1:0];
  assign w_za     = (w_ea == '0);
  assign w_zb     = (w_eb == '0);
  assign w_fa     = w_za ? '0 : w_fa_raw;
  assign w_fb     = w_zb ? '0 : w_fb_raw;
  assign w_nan_a  = (w_ea == EXP_ONES) && (w_fa_raw != '0);
  assign w_nan_b  = (w_eb == EXP_ONES) && (w_fb_raw != '0);
  assign w_snan_a = w_nan_a && !w_fa_raw[FRAC_W-1];
  assign w_snan_b = w_nan_b && !w_fb_raw[FRAC_W-1];
  assign w_inf_a  = (w_ea == EXP_ONES) && (w_fa_raw == '0);
  assign w_inf_b  = (w_eb == EXP_ONES) && (w_fb_raw == '0);
  assign w_sig_a  = w_za ? '0 : {1'b1, w_fa, 3'b000};
  assign w_sig_b  = w_zb ? '0 : {1'b1, w_fb, 3'b000};

  logic         w_spec;
  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_flg;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = '0;
    w_spec_flg = '0;
    if (w_nan_a || w_nan_b) begin
      w_spec_res          = QNAN;
      w_spec_flg[FLAG_NV] = w_snan_a || w_snan_b;
    end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
      w_spec_res          = QNAN;
      w_spec_flg[FLAG_NV] = 1'b1;
    end else if (w_inf_a) begin
      w_spec_res = {w_sa, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (w_inf_b) begin
      w_spec_res = {w_sb, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (w_za && w_zb) begin
      w_spec_res = {w_sa && w_sb, {(W-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

  logic             w_a_big, w_s_big;
  logic [EXP_W-1:0] w_e_big, w_e_sm, w_d;
  logic [M-1:0]     w_sig_big, w_sig_sm, w_sm_sh, w_sm_lost, w_sm_al;

  assign w_a_big   = {w_ea, w_fa} >= {w_eb, w_fb};
  assign w_s_big   = w_a_big ? w_sa : w_sb;
  assign w_e_big   = w_a_big ? w_ea : w_eb;
  assign w_e_sm    = w_a_big ? w_eb : w_ea;
  assign w_sig_big = w_a_big ? w_sig_a : w_sig_b;
  assign w_sig_sm  = w_a_big ? w_sig_b : w_sig_a;
  assign w_d       = w_e_big - w_e_sm;
  // Shifts of M or more clear the shifted value and push everything into lost,
  // so huge exponent gaps collapse to a lone sticky bit without a special case.
  assign w_sm_sh   = w_sig_sm >> w_d;
  assign w_sm_lost = w_sig_sm & ~({M{1'b1}} << w_d);
  assign w_sm_al   = {w_sm_sh[M-1:1], w_sm_sh[0] | (|w_sm_lost)};

  logic             r_s1_spec, r_s1_sign, r_s1_esub;
  logic [W-1:0]     r_s1_spec_res;
  logic [3:0]       r_s1_spec_flg;
  logic [EXP_W-1:0] r_s1_exp;
  logic [M-1:0]     r_s1_big, r_s1_sm;

  // ---------------- stage 2: add and count leading zeros
  logic [S-1:0]  w_sum;
  logic [CW-1:0] w_lzc;
  logic          w_sum_zero;

  assign w_sum = r_s1_esub ? ({1'b0, r_s1_big} - {1'b0, r_s1_sm})
                           : ({1'b0, r_s1_big} + {1'b0, r_s1_sm});

  fpu_lzc #(.WIDTH(S)) u_lzc (
    .i_data  (w_sum),
    .o_count (w_lzc),
    .o_zero  (w_sum_zero)
  );

  logic             r_s2_spec, r_s2_sign, r_s2_zero;
  logic [W-1:0]     r_s2_spec_res;
  logic [3:0]       r_s2_spec_flg;
  logic [EXP_W-1:0] r_s2_exp;
  logic [S-1:0]     r_s2_sum;
  logic [CW-1:0]    r_s2_lzc;

  // ---------------- stage 3: normalise, round, pack
  logic [CW-1:0]     w_shamt;
  logic [S-2:0]      w_shl, w_norm;
  logic [FRAC_W:0]   w_mant;
  logic              w_g, w_r, w_st, w_inc, w_rc, w_of, w_uf;
  logic [FRAC_W+1:0] w_rnd;
  logic [FRAC_W-1:0] w_frac;
  logic [EP-1:0]     w_e;

  // A carry out of the adder means lzc is 0, so exp+1-lzc covers both cases.
  assign w_shamt = r_s2_lzc - CW'(1);
  assign w_shl   = (S-1)'(r_s2_sum << w_shamt);
  assign w_norm  = r_s2_sum[S-1] ? {r_s2_sum[S-1:2], r_s2_sum[1] | r_s2_sum[0]} : w_shl;
  assign w_mant  = w_norm[S-2:3];
  assign w_g     = w_norm[2];
  assign w_r     = w_norm[1];
  assign w_st    = w_norm[0];
  assign w_inc   = w_g && (w_r || w_st || w_mant[0]);
  assign w_rnd   = {1'b0, w_mant} + (FRAC_W+2)'(w_inc);
  assign w_rc    = w_rnd[FRAC_W+1];
  assign w_frac  = w_rc ? w_rnd[FRAC_W:1] : w_rnd[FRAC_W-1:0];
  assign w_e     = EP'(r_s2_exp) + EP'(1) - EP'(r_s2_lzc) + EP'(w_rc);
  assign w_of    = !w_e[EP-1] && (w_e >= E_OVF);
  assign w_uf    = w_e[EP-1] || (w_e == '0);

  logic [W-1:0] w_res;
  logic [3:0]   w_flg;

  always_comb begin
    w_res          = {r_s2_sign, w_e[EXP_W-1:0], w_frac};
    w_flg          = '0;
    w_flg[FLAG_NX] = w_g || w_r || w_st;
    if (r_s2_spec) begin
      w_res = r_s2_spec_res;
      w_flg = r_s2_spec_flg;
    end else if (r_s2_zero) begin
      w_res = '0;
      w_flg = '0;
    end else if (w_of) begin
      w_res          = {r_s2_sign, EXP_ONES, {FRAC_W{1'b0}}};
      w_flg[FLAG_OF] = 1'b1;
      w_flg[FLAG_NX] = 1'b1;
    end else if (w_uf) begin
      w_res          = {r_s2_sign, {(W-1){1'b0}}};
      w_flg[FLAG_UF] = 1'b1;
      w_flg[FLAG_NX] = 1'b1;
    end
  end

  // ---------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (r_v2) begin
        r_result <= w_res;
        r_flags  <= w_flg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && w_en) begin
      r_s1_spec     <= w_spec;
      r_s1_spec_res <= w_spec_res;
      r_s1_spec_flg <= w_spec_flg;
      r_s1_sign     <= w_s_big;
      r_s1_esub     <= w_sa ^ w_sb;
      r_s1_exp      <= w_e_big;
      r_s1_big      <= w_sig_big;
      r_s1_sm       <= w_sm_al;
    end
    if (r_v1 && w_en) begin
      r_s2_spec     <= r_s1_spec;
      r_s2_spec_res <= r_s1_spec_res;
      r_s2_spec_flg <= r_s1_spec_flg;
      r_s2_sign     <= r_s1_sign;
      r_s2_exp      <= r_s1_exp;
      r_s2_sum      <= w_sum;
      r_s2_lzc      <= w_lzc;
      r_s2_zero     <= w_sum_zero;
    end
  end

endmodule

// File: doc/faddsub_pipe.md
# faddsub_pipe

Parametrised, fully pipelined IEEE-754 floating-point adder/subtractor for the FPU. It takes two operands plus an add/sub select and returns a correctly rounded (round-to-nearest-even) sum after three register stages. It provides exception flags and a valid/ready handshake so the FPU issue logic can stall it. Widths are parameters; binary32 is the default.

## Interface
- `EXP_W`, default 8: exponent field width.
- `FRAC_W`, default 23: stored fraction width. Word width is `W = 1+EXP_W+FRAC_W`.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: `op1`, `op2` and `sub` are valid this cycle.
- `in_ready` out 1: the block accepts input this cycle.
- `op1` in W: operand 1.
- `op2` in W: operand 2.
- `sub` in 1: 1 computes `op1 - op2` (the sign of `op2` is inverted before alignment).
- `out_valid` out 1: `result` and `flags` are valid.
- `out_ready` in 1: the consumer takes the result this cycle.
- `result` out W: rounded sum.
- `flags` out 4: `{invalid, overflow, underflow, inexact}`.

## Operation
- Denormal inputs (exp==0) are flushed to signed zero; no hidden bit is inserted for them.
- Stage 1, align:
  - Select the larger magnitude by `{exp,frac}` compare and swap operands.
  - Significands are `{1, frac, 3'b000}` (guard/round/sticky).
  - Right-shift the smaller operand by the exponent difference, ORing all lost bits into sticky.
  - A difference ≥ FRAC_W+4 reduces the smaller operand to sticky only.
- Stage 2, add:
  - Effective subtract is `sign_big ^ sign_small`; the adder is FRAC_W+5 bits including carry.
  - A leading-zero count is taken on the sum.
- Stage 3, normalise, round, pack:
  - Shift left by the LZC, or right by 1 on carry, keeping sticky.
  - Round to nearest even: increment when `G & (R|S|LSB)`. A rounding carry-out renormalises and bumps the exponent.
  - The exponent is computed in EXP_W+2 signed.
  - Overflow (≥ all-ones): ±inf, `overflow=1`, `inexact=1`.
  - Underflow (≤0): signed zero, `underflow=1`, `inexact=1`.
- Special cases:
  - Either operand NaN: result is canonical qNaN `{0, all-ones exp, 1, 0...}`; `invalid=1` only for sNaN.
  - inf − inf (effective): canonical qNaN, `invalid=1`.
  - inf ± finite: that inf, flags 0.
  - Exact-zero sum of nonzero operands: +0.
  - (+0)+(+0) gives +0 and (−0)+(−0) gives −0; mixed-sign zero addition gives +0.
- `inexact` = any of G/R/S nonzero after normalisation, or overflow/underflow.

## Timing
- Latency: exactly 3 cycles from an accepted input to `out_valid` when not stalled. Throughput is 1 per cycle.
- Pipeline enable: `en = !out_valid | out_ready`, and `in_ready = en`, combinationally.
  - All three stages advance together; internal bubbles are not collapsed.
- An input is accepted when `in_valid & in_ready`. The stage-1 valid bit loads `in_valid & en`.
- While `out_valid & !out_ready`:
  - `result` and `flags` hold stable;
  - no stage advances;
  - `in_ready=0`.
- Output is consumed on `out_valid & out_ready`. A new result may be presented in the same edge (back-to-back).
- Reset:
  - All stage valid bits go to 0; `out_valid=0`, `result=0`, `flags=0`.
  - Data registers may be left unreset.
  - Reset mid-stream drops all in-flight operations; `in_ready=1` on the first cycle after reset.
- `sub`, `op1` and `op2` are sampled only on accept.

## Structure
- Shared package `fpu_pkg`:
  - `EXP_W`/`FRAC_W` defaults;
  - flag bit index constants (`FLAG_NV`, `FLAG_OF`, `FLAG_UF`, `FLAG_NX`);
  - canonical qNaN constant function;
  - round-mode enum (RNE only for now, reserved for future modes).
- Sub-module `fpu_lzc`: parametrised leading-zero counter (width param, count output `$clog2(width+1)` bits, all-zero output), reusable by fmul/fsub normalisation.
- The pipeline, handshake and rounding stay in `faddsub_pipe`.

## Test plan
- 0x3F800000 + 0x40000000, `sub=0`, `out_ready=1` → exactly 3 cycles later `out_valid=1`, `result=0x40400000`, `flags=0`.
- 0x3F800000 + 0xBF800000 → 0x00000000. Separately, `sub=1` with 0x3F800000, 0x3F800000 → 0x00000000. Flags 0 in both.
- RNE:
  - 0x3F800000 + 0x33800000 → 0x3F800000, `inexact=1`.
  - 0x3F800001 + 0x33800000 → 0x3F800002, `inexact=1`.
- Limits:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `flags=0b0101`.
  - 0x00800001 − 0x00800000 → 0x00000000, `flags=0b0011`.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, `invalid=1`. 0x7FA00000 + 0x3F800000 → 0x7FC00000, `invalid=1`.
- Backpressure and reset:
  - Stream 5 ops back-to-back, hold `out_ready=0` for 6 cycles, then release.
  - Required: `in_ready=0` while stalled, `result` stable, all 5 results in order with no loss or duplication.
  - Then assert `reset` with 2 ops in flight: `out_valid=0` next cycle and no stale results appear.
